// File: rtl/frame_pkg.sv
// +--------------------------------------------------------------------+
// | frame_pkg: register map, bit positions and FSM states for the       |
// | frame_monitor sink.                       Revision: 1.0             |
// +--------------------------------------------------------------------+
`default_nettype none

package frame_pkg;

   localparam logic [7:0] ADDR_GAP    = 8'd0;
   localparam logic [7:0] ADDR_CTRL   = 8'd1;
   localparam logic [7:0] ADDR_CSUM0  = 8'd2;
   localparam logic [7:0] ADDR_CSUM1  = 8'd3;
   localparam logic [7:0] ADDR_CSUM2  = 8'd4;
   localparam logic [7:0] ADDR_CSUM3  = 8'd5;
   localparam logic [7:0] ADDR_COUNT0 = 8'd6;
   localparam logic [7:0] ADDR_COUNT1 = 8'd7;
   localparam logic [7:0] ADDR_STATUS = 8'd8;

   localparam int CTRL_ENABLE_BIT     = 0;
   localparam int CTRL_CLEAR_BIT      = 1;
   localparam int STATUS_IN_FRAME_BIT = 0;
   localparam int STATUS_GAP_BIT      = 1;
   localparam int STATUS_IRQ_BIT      = 2;

   // Values driven when the interrupt feature is built out, and for unmapped reads.
   localparam logic       STUB_IRQ  = 1'b0;
   localparam logic [7:0] STUB_READ = 8'h00;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RECV = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/frame_monitor_regs.sv
// +--------------------------------------------------------------------+
// | frame_monitor_regs: Avalon-MM byte register file, read mux,         |
// | clear-stats pulse, irq pending (FRAME_MONITOR_IRQ_EN). Rev: 1.0     |
// +--------------------------------------------------------------------+
`default_nettype none

module frame_monitor_regs
   import frame_pkg::*;
#(
   parameter int GAP_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       writedata,
   input  logic             write,
   input  logic             chipselect,
   input  logic [7:0]       address,
   input  logic             read,
   output logic [7:0]       readdata,
   output logic             irq,
   input  logic             in_frame,
   input  logic             gap_active,
   input  logic             frame_done,
   input  logic [31:0]      checksum,
   input  logic [15:0]      frame_count,
   output logic             enable,
   output logic             clear_stats,
   output logic [GAP_W-1:0] gap_cfg
);

   logic       wr_en;
   logic       rd_en;
   logic       irq_pending;
   logic [7:0] rd_mux;

   assign wr_en = chipselect && write;
   assign rd_en = chipselect && read;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gap_cfg     <= '0;
         enable      <= 1'b0;
         clear_stats <= 1'b0;
      end else begin
         clear_stats <= wr_en && (address == ADDR_CTRL) && writedata[CTRL_CLEAR_BIT];
         if (wr_en && (address == ADDR_GAP))
            gap_cfg <= writedata[GAP_W-1:0];
         if (wr_en && (address == ADDR_CTRL))
            enable <= writedata[CTRL_ENABLE_BIT];
      end
   end

`ifdef FRAME_MONITOR_IRQ_EN
   // A completion on the same cycle as the clearing STATUS read takes priority.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         irq_pending <= 1'b0;
      else if (frame_done)
         irq_pending <= 1'b1;
      else if (rd_en && (address == ADDR_STATUS))
         irq_pending <= 1'b0;
   end
`else
   logic unused_frame_done;
   assign unused_frame_done = frame_done;
   assign irq_pending       = STUB_IRQ;
`endif

   assign irq = irq_pending;

   always_comb begin
      rd_mux = STUB_READ;
      case (address)
         ADDR_GAP:    rd_mux = 8'(gap_cfg);
         ADDR_CTRL:   rd_mux[CTRL_ENABLE_BIT] = enable;
         ADDR_CSUM0:  rd_mux = checksum[7:0];
         ADDR_CSUM1:  rd_mux = checksum[15:8];
         ADDR_CSUM2:  rd_mux = checksum[23:16];
         ADDR_CSUM3:  rd_mux = checksum[31:24];
         ADDR_COUNT0: rd_mux = frame_count[7:0];
         ADDR_COUNT1: rd_mux = frame_count[15:8];
         ADDR_STATUS: begin
            rd_mux[STATUS_IN_FRAME_BIT] = in_frame;
            rd_mux[STATUS_GAP_BIT]      = gap_active;
            rd_mux[STATUS_IRQ_BIT]      = irq_pending;
         end
         default:     rd_mux = STUB_READ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         readdata <= '0;
      else if (rd_en)
         readdata <= rd_mux;
   end

endmodule

`default_nettype wire

// File: rtl/frame_monitor.sv
// +--------------------------------------------------------------------+
// | frame_monitor: AXI-Stream frame sink with checksum, frame count and |
// | programmable inter-frame gap. Option: FRAME_MONITOR_IRQ_EN. Rev 1.0 |
// +--------------------------------------------------------------------+
`default_nettype none

module frame_monitor
   import frame_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int GAP_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        writedata,
   input  logic              write,
   input  logic              chipselect,
   input  logic [7:0]        address,
   input  logic              read,
   output logic [7:0]        readdata,
   output logic              irq,
   input  logic [DATA_W-1:0] ingress_port_tdata,
   input  logic              ingress_port_tvalid,
   output logic              ingress_port_tready,
   input  logic              ingress_port_tlast
);

   state_t           state;
   state_t           state_nxt;
   logic [GAP_W-1:0] gap_cnt;
   logic [GAP_W-1:0] gap_cnt_nxt;
   logic [GAP_W-1:0] gap_cfg;
   logic             enable;
   logic             clear_stats;
   logic             accept;
   logic             frame_done;
   logic [31:0]      run_sum;
   logic [31:0]      checksum;
   logic [15:0]      frame_count;

   assign ingress_port_tready = enable && (state != ST_GAP);
   assign accept              = ingress_port_tvalid && ingress_port_tready;
   assign frame_done          = accept && ingress_port_tlast && !clear_stats;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         gap_cnt <= '0;
      end else begin
         state   <= state_nxt;
         gap_cnt <= gap_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      gap_cnt_nxt = gap_cnt;
      case (state)
         ST_IDLE, ST_RECV: begin
            if (accept) begin
               if (!ingress_port_tlast) begin
                  state_nxt = ST_RECV;
               end else if (gap_cfg != '0) begin
                  state_nxt   = ST_GAP;
                  gap_cnt_nxt = gap_cfg;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt <= GAP_W'(1))
               state_nxt = ST_IDLE;
            else
               gap_cnt_nxt = gap_cnt - GAP_W'(1);
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (clear_stats)
         state_nxt = ST_IDLE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         run_sum     <= '0;
         checksum    <= '0;
         frame_count <= '0;
      end else if (clear_stats) begin
         run_sum     <= '0;
         checksum    <= '0;
         frame_count <= '0;
      end else if (accept) begin
         if (ingress_port_tlast) begin
            checksum    <= run_sum + 32'(ingress_port_tdata);
            run_sum     <= '0;
            frame_count <= frame_count + 16'd1;
         end else begin
            run_sum <= run_sum + 32'(ingress_port_tdata);
         end
      end
   end

   frame_monitor_regs #(
      .GAP_W (GAP_W)
   ) u_regs (
      .clk         (clk),
      .reset       (reset),
      .writedata   (writedata),
      .write       (write),
      .chipselect  (chipselect),
      .address     (address),
      .read        (read),
      .readdata    (readdata),
      .irq         (irq),
      .in_frame    (state == ST_RECV),
      .gap_active  (state == ST_GAP),
      .frame_done  (frame_done),
      .checksum    (checksum),
      .frame_count (frame_count),
      .enable      (enable),
      .clear_stats (clear_stats),
      .gap_cfg     (gap_cfg)
   );

endmodule

`default_nettype wire

// File: tb/tb_frame_monitor.sv
// +--------------------------------------------------------------------+
// | tb_frame_monitor: randomized and directed self-checking bench for   |
// | frame_monitor (16-bit and 32-bit instances).         Revision: 1.0  |
// +--------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_frame_monitor;

   localparam int DATA_W = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic [7:0]        writedata, address, readdata, readdata32;
   logic              write, read, chipselect, chipselect32, irq, irq32;
   logic [DATA_W-1:0] tdata;
   logic              tvalid, tready, tlast;
   logic [31:0]       tdata32;
   logic              tvalid32, tready32, tlast32;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   frame_monitor #(.DATA_W(DATA_W), .GAP_W(8)) dut (
      .clk (clk), .reset (reset), .writedata (writedata), .write (write),
      .chipselect (chipselect), .address (address), .read (read),
      .readdata (readdata), .irq (irq),
      .ingress_port_tdata (tdata), .ingress_port_tvalid (tvalid),
      .ingress_port_tready (tready), .ingress_port_tlast (tlast)
   );

   frame_monitor #(.DATA_W(32), .GAP_W(8)) dut32 (
      .clk (clk), .reset (reset), .writedata (writedata), .write (write),
      .chipselect (chipselect32), .address (address), .read (read),
      .readdata (readdata32), .irq (irq32),
      .ingress_port_tdata (tdata32), .ingress_port_tvalid (tvalid32),
      .ingress_port_tready (tready32), .ingress_port_tlast (tlast32)
   );

   task automatic reg_write(input logic [7:0] a, input logic [7:0] d, input bit to32);
      @(negedge clk);
      address = a; writedata = d; write = 1'b1;
      if (to32) chipselect32 = 1'b1; else chipselect = 1'b1;
      @(negedge clk);
      write = 1'b0; chipselect = 1'b0; chipselect32 = 1'b0;
   endtask

   task automatic reg_read(input logic [7:0] a, output logic [7:0] d, input bit to32);
      @(negedge clk);
      address = a; read = 1'b1;
      if (to32) chipselect32 = 1'b1; else chipselect = 1'b1;
      @(negedge clk);
      read = 1'b0; chipselect = 1'b0; chipselect32 = 1'b0;
      d = to32 ? readdata32 : readdata;
   endtask

   task automatic read_checksum(input bit to32, output logic [31:0] v);
      logic [7:0] b;
      for (int i = 0; i < 4; i++) begin
         reg_read(8'(2 + i), b, to32);
         v[8*i +: 8] = b;
      end
   endtask

   task automatic read_count(output logic [15:0] v);
      logic [7:0] b;
      reg_read(8'd6, b, 1'b0);
      v[7:0] = b;
      reg_read(8'd7, b, 1'b0);
      v[15:8] = b;
   endtask

   // Presents one beat after 'idle' empty cycles; waits = cycles stalled, -1 on timeout.
   task automatic send_beat(input bit to32, input logic [31:0] d, input logic last,
                            input int idle, output int waits);
      for (int i = 0; i < idle; i++) @(negedge clk);
      @(negedge clk);
      if (to32) begin tdata32 = d; tlast32 = last; tvalid32 = 1'b1; end
      else begin tdata = d[DATA_W-1:0]; tlast = last; tvalid = 1'b1; end
      waits = 0;
      while (!(to32 ? tready32 : tready) && waits < 100) begin
         @(negedge clk);
         waits++;
      end
      if (to32 ? tready32 : tready) @(posedge clk);
      else waits = -1;
      #1;
      tvalid = 1'b0; tlast = 1'b0; tvalid32 = 1'b0; tlast32 = 1'b0;
   endtask

   task automatic test_reset;
      logic [7:0] d;
      compared++;
      if (tready !== 1'b0 || irq !== 1'b0 || readdata !== 8'h00) begin
         mismatched++;
         $display("FAIL reset_outputs: tready=%b irq=%b readdata=%h required 0 0 00", tready, irq, readdata);
      end
      for (int a = 0; a < 10; a++) begin
         reg_read(8'(a), d, 1'b0);
         compared++;
         if (d !== 8'h00) begin
            mismatched++;
            $display("FAIL reset_reg[%0d]: got %h required 00", a, d);
         end
      end
   endtask

   task automatic test_enable;
      logic [7:0] d;
      reg_write(8'd1, 8'h01, 1'b0);
      compared++;
      if (tready !== 1'b1) begin
         mismatched++;
         $display("FAIL enable_tready: got %b required 1", tready);
      end
      reg_read(8'd1, d, 1'b0);
      compared++;
      if (d !== 8'h01) begin
         mismatched++;
         $display("FAIL ctrl_readback: got %h required 01", d);
      end
   endtask

   task automatic test_basic_frame;
      logic [31:0] cs;
      logic [15:0] cnt;
      int w, tot;
      reg_write(8'd0, 8'd0, 1'b0);
      reg_write(8'd1, 8'h03, 1'b0);
      tot = 0;
      send_beat(1'b0, 32'h0001, 1'b0, 0, w); tot += w;
      send_beat(1'b0, 32'h0002, 1'b0, 0, w); tot += w;
      send_beat(1'b0, 32'hFFFF, 1'b1, 0, w); tot += w;
      compared++;
      if (tot !== 0) begin
         mismatched++;
         $display("FAIL basic_stalls: got %0d required 0", tot);
      end
      read_checksum(1'b0, cs);
      read_count(cnt);
      compared++;
      if (cs !== 32'h0001_0002 || cnt !== 16'd1) begin
         mismatched++;
         $display("FAIL basic_frame: checksum=%h count=%0d required 00010002 1", cs, cnt);
      end
   endtask

   task automatic test_gap;
      logic [15:0] cnt;
      int w;
      reg_write(8'd0, 8'd3, 1'b0);
      reg_write(8'd1, 8'h03, 1'b0);
      send_beat(1'b0, 32'h0011, 1'b0, 0, w);
      send_beat(1'b0, 32'h0022, 1'b1, 0, w);
      send_beat(1'b0, 32'h0033, 1'b1, 0, w);
      compared++;
      if (w !== 3) begin
         mismatched++;
         $display("FAIL gap_length: stalled %0d cycles required 3", w);
      end
      read_count(cnt);
      compared++;
      if (cnt !== 16'd2) begin
         mismatched++;
         $display("FAIL gap_count: got %0d required 2", cnt);
      end
      reg_write(8'd0, 8'd0, 1'b0);
   endtask

   task automatic test_wrap32;
      logic [31:0] cs;
      int w;
      reg_write(8'd1, 8'h01, 1'b1);
      send_beat(1'b1, 32'hFFFF_FFFF, 1'b0, 0, w);
      send_beat(1'b1, 32'h0000_0002, 1'b1, 0, w);
      read_checksum(1'b1, cs);
      compared++;
      if (cs !== 32'h0000_0001) begin
         mismatched++;
         $display("FAIL wrap32_checksum: got %h required 00000001", cs);
      end
   endtask

   task automatic test_enable_mid_frame;
      logic [7:0]  d;
      logic [31:0] cs;
      int w, seen;
      reg_write(8'd1, 8'h03, 1'b0);
      send_beat(1'b0, 32'd10, 1'b0, 0, w);
      reg_write(8'd1, 8'h00, 1'b0);
      reg_read(8'd8, d, 1'b0);
      compared++;
      if (d[1:0] !== 2'b01) begin
         mismatched++;
         $display("FAIL held_in_frame: status=%h required in-frame only", d);
      end
      @(negedge clk);
      tdata = 16'd20; tlast = 1'b1; tvalid = 1'b1;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         if (tready) seen++;
         @(negedge clk);
      end
      compared++;
      if (seen !== 0) begin
         mismatched++;
         $display("FAIL disabled_tready: high %0d cycles required 0", seen);
      end
      reg_write(8'd1, 8'h01, 1'b0);
      @(posedge clk);
      #1;
      tvalid = 1'b0; tlast = 1'b0;
      read_checksum(1'b0, cs);
      compared++;
      if (cs !== 32'd30) begin
         mismatched++;
         $display("FAIL resume_checksum: got %h required 0000001e", cs);
      end
   endtask

   task automatic test_clear_on_tlast;
      logic [7:0]  d;
      logic [31:0] cs;
      logic [15:0] cnt;
      int w;
      reg_write(8'd0, 8'd5, 1'b0);
      send_beat(1'b0, 32'h0040, 1'b0, 0, w);
      @(negedge clk);
      tdata = 16'h0005; tlast = 1'b1; tvalid = 1'b1;
      address = 8'd1; writedata = 8'h03; write = 1'b1; chipselect = 1'b1;
      @(posedge clk);
      #1;
      tvalid = 1'b0; tlast = 1'b0; write = 1'b0; chipselect = 1'b0;
      @(negedge clk);
      @(negedge clk);
      compared++;
      if (tready !== 1'b1) begin
         mismatched++;
         $display("FAIL clear_tready: got %b required 1", tready);
      end
      reg_read(8'd8, d, 1'b0);
      read_checksum(1'b0, cs);
      read_count(cnt);
      compared++;
      if (d[1:0] !== 2'b00 || cs !== 32'd0 || cnt !== 16'd0) begin
         mismatched++;
         $display("FAIL clear_on_tlast: status=%h checksum=%h count=%0d required idle 0 0", d, cs, cnt);
      end
      reg_write(8'd0, 8'd0, 1'b0);
   endtask

   task automatic test_count_wrap;
      logic [15:0] cnt;
      int w;
      reg_write(8'd1, 8'h03, 1'b0);
      @(negedge clk);
      force dut.frame_count = 16'hFFFE;
      @(negedge clk);
      release dut.frame_count;
      read_count(cnt);
      compared++;
      if (cnt !== 16'hFFFE) begin
         mismatched++;
         $display("FAIL count_preset: got %h required fffe", cnt);
      end
      send_beat(1'b0, 32'h0001, 1'b1, 0, w);
      read_count(cnt);
      compared++;
      if (cnt !== 16'hFFFF) begin
         mismatched++;
         $display("FAIL count_ffff: got %h required ffff", cnt);
      end
      send_beat(1'b0, 32'h0001, 1'b1, 0, w);
      read_count(cnt);
      compared++;
      if (cnt !== 16'h0000) begin
         mismatched++;
         $display("FAIL count_wrap: got %h required 0000", cnt);
      end
   endtask

   task automatic test_random;
      logic [31:0] cs, model_sum;
      logic [15:0] cnt, model_cnt;
      int w, stalls, nbeats;
      logic [DATA_W-1:0] beat;
      reg_write(8'd1, 8'h03, 1'b0);
      model_cnt = 16'd0;
      for (int f = 0; f < 16; f++) begin
         reg_write(8'd0, 8'($urandom_range(0, 3)), 1'b0);
         nbeats = $urandom_range(1, 6);
         model_sum = 32'd0;
         stalls = 0;
         for (int b = 0; b < nbeats; b++) begin
            beat = DATA_W'($urandom);
            model_sum = model_sum + 32'(beat);
            send_beat(1'b0, 32'(beat), (b == nbeats - 1), $urandom_range(0, 2), w);
            stalls += w;
         end
         model_cnt = model_cnt + 16'd1;
         read_checksum(1'b0, cs);
         read_count(cnt);
         compared++;
         if (stalls !== 0 || cs !== model_sum || cnt !== model_cnt) begin
            mismatched++;
            $display("FAIL random_frame[%0d]: stalls=%0d checksum=%h count=%0d required 0 %h %0d",
                     f, stalls, cs, cnt, model_sum, model_cnt);
         end
      end
      reg_write(8'd0, 8'd0, 1'b0);
   endtask

   task automatic test_reset_mid_frame;
      logic [31:0] cs;
      int w;
      send_beat(1'b0, 32'h0100, 1'b0, 0, w);
      @(negedge clk);
      reset = 1'b1;
      #1;
      compared++;
      if (tready !== 1'b0) begin
         mismatched++;
         $display("FAIL async_reset_tready: got %b required 0", tready);
      end
      @(negedge clk);
      reset = 1'b0;
      reg_write(8'd1, 8'h01, 1'b0);
      send_beat(1'b0, 32'h0007, 1'b1, 0, w);
      read_checksum(1'b0, cs);
      compared++;
      if (cs !== 32'd7) begin
         mismatched++;
         $display("FAIL reset_discard: got %h required 00000007", cs);
      end
   endtask

   task automatic test_irq;
      logic [7:0] d;
      int w;
      reg_write(8'd1, 8'h03, 1'b0);
      reg_read(8'd8, d, 1'b0);
      send_beat(1'b0, 32'h0009, 1'b1, 0, w);
      @(negedge clk);
`ifdef FRAME_MONITOR_IRQ_EN
      compared++;
      if (irq !== 1'b1) begin
         mismatched++;
         $display("FAIL irq_set: got %b required 1", irq);
      end
      reg_read(8'd8, d, 1'b0);
      compared++;
      if (d !== 8'h04 || irq !== 1'b0) begin
         mismatched++;
         $display("FAIL irq_clear: status=%h irq=%b required 04 0", d, irq);
      end
`else
      reg_read(8'd8, d, 1'b0);
      compared++;
      if (irq !== 1'b0 || d !== 8'h00) begin
         mismatched++;
         $display("FAIL irq_disabled: irq=%b status=%h required 0 00", irq, d);
      end
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      writedata = '0; address = '0; write = 1'b0; read = 1'b0;
      chipselect = 1'b0; chipselect32 = 1'b0;
      tdata = '0; tvalid = 1'b0; tlast = 1'b0;
      tdata32 = '0; tvalid32 = 1'b0; tlast32 = 1'b0;
      repeat (3) @(negedge clk);
      test_reset;
      reset = 1'b0;
      test_reset;
      test_enable;
      test_basic_frame;
      test_gap;
      test_wrap32;
      test_enable_mid_frame;
      test_clear_on_tlast;
      test_count_wrap;
      test_random;
      test_reset_mid_frame;
      test_irq;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

`default_nettype wire
